// File: rtl/dm_sba_bus.sv
// dm_sba_bus: system bus access engine for the RISC-V debug module.
// Turns sbaddress/sbdata accesses into req/gnt/rvalid bus transactions.
module dm_sba_bus #(
    parameter int unsigned BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic                  sbaddress_update_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);
    localparam int unsigned BeW  = BusWidth / 8;
    localparam int unsigned OffW = $clog2(BeW);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE
    } state_e;

    state_e              state_q, state_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [BusWidth-1:0] data_q, data_d;
    logic [2:0]          size_q, size_d;
    logic                autoinc_q, autoinc_d;
    logic                abort_q, abort_d;

    logic [OffW-1:0]     off;
    logic [OffW+2:0]     shamt;
    logic [BusWidth-1:0] size_mask, addr_inc;
    logic [BeW-1:0]      be;
    logic                go_rd, go_wr, pre_size, pre_align, keep;

    assign off      = addr_q[OffW-1:0];
    assign shamt    = {off, 3'b000};
    assign addr_inc = addr_q + (BusWidth'(1) << size_q);
    assign keep     = dmactive_i && !abort_q;

    assign go_rd = dmactive_i &&
                   ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                    (!sbdata_write_valid_i && sbdata_read_valid_i && sbreadondata_i));
    assign go_wr = dmactive_i && sbdata_write_valid_i &&
                   !(sbaddress_write_valid_i && sbreadonaddr_i);
    assign pre_size = sbaccess_i > 3'(OffW);

    always_comb begin
        pre_align = 1'b0;
        for (int i = 0; i < int'(OffW); i++)
            if (i < int'(sbaccess_i) && sbaddress_i[i]) pre_align = 1'b1;
    end

    // Byte-lane masks derived from the captured size and address offset.
    always_comb begin
        for (int i = 0; i < int'(BeW); i++)
            be[i] = (i >= int'(off)) && (((i - int'(off)) >> size_q) == 0);
        for (int i = 0; i < int'(BusWidth); i++)
            size_mask[i] = ((i / 8) >> size_q) == 0;
    end

    assign sbbusy_o       = state_q != IDLE;
    assign master_req_o   = (state_q == READ) || (state_q == WRITE);
    assign master_we_o    = state_q == WRITE;
    assign master_add_o   = master_req_o ? (addr_q & ~BusWidth'(BeW - 1)) : '0;
    assign master_be_o    = master_req_o ? be : '0;
    assign master_wdata_o = master_we_o ? (data_q << shamt) : '0;

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        data_d             = data_q;
        size_d             = size_q;
        autoinc_d          = autoinc_q;
        abort_d            = abort_q;
        sberror_valid_o    = 1'b0;
        sberror_o          = 3'd0;
        sbdata_valid_o     = 1'b0;
        sbdata_o           = '0;
        sbaddress_update_o = 1'b0;
        sbaddress_o        = addr_q;
        unique case (state_q)
            IDLE: begin
                if (go_rd || go_wr) begin
                    if (pre_size) begin
                        sberror_valid_o = 1'b1;
                        sberror_o       = 3'd4;
                    end else if (pre_align) begin
                        sberror_valid_o = 1'b1;
                        sberror_o       = 3'd3;
                    end else begin
                        addr_d    = sbaddress_i;
                        data_d    = sbdata_i;
                        size_d    = sbaccess_i;
                        autoinc_d = sbautoincrement_i;
                        abort_d   = 1'b0;
                        state_d   = go_rd ? READ : WRITE;
                    end
                end
            end
            READ, WRITE: begin
                if (!dmactive_i) abort_d = 1'b1;
                if (master_gnt_i)
                    state_d = (state_q == READ) ? WAIT_READ : WAIT_WRITE;
            end
            WAIT_READ, WAIT_WRITE: begin
                if (!dmactive_i) abort_d = 1'b1;
                // A deactivated module still drains the bus, but reports nothing.
                if (master_r_valid_i) begin
                    state_d = IDLE;
                    if (keep && master_r_err_i) begin
                        sberror_valid_o = 1'b1;
                        sberror_o       = 3'd2;
                    end else if (keep) begin
                        if (state_q == WAIT_READ) begin
                            sbdata_valid_o = 1'b1;
                            sbdata_o       = (master_r_rdata_i >> shamt) & size_mask;
                        end
                        if (autoinc_q) begin
                            sbaddress_update_o = 1'b1;
                            sbaddress_o        = addr_inc;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            autoinc_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
            autoinc_q <= autoinc_d;
            abort_q   <= abort_d;
        end
    end
endmodule

// File: tb/tb_dm_sba_bus.sv
// tb_dm_sba_bus: directed vectors for dm_sba_bus on a 64-bit and a 32-bit
// instance; use32 selects which one is active and observed.
module tb_dm_sba_bus;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        dmactive = 1'b1, use32 = 1'b0;
    logic        gnt = 0, rvalid = 0, rerr = 0;
    logic [63:0] rdata = '0, sbaddress = '0, sbdata = '0;
    logic        aw = 0, roa = 0, rod = 0, ainc = 0, dw = 0, dr = 0;
    logic [2:0]  acc = '0;

    logic        req64, we64, upd64, dv64, busy64, ev64;
    logic [63:0] add64, wd64, sa64, sd64;
    logic [7:0]  be64;
    logic [2:0]  err64;
    logic        req32, we32, upd32, dv32, busy32, ev32;
    logic [31:0] add32, wd32, sa32, sd32;
    logic [3:0]  be32;
    logic [2:0]  err32;

    dm_sba_bus #(.BusWidth(64)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive && !use32),
        .master_req_o(req64), .master_add_o(add64), .master_we_o(we64),
        .master_wdata_o(wd64), .master_be_o(be64), .master_gnt_i(gnt),
        .master_r_valid_i(rvalid), .master_r_rdata_i(rdata),
        .master_r_err_i(rerr), .sbaddress_i(sbaddress),
        .sbaddress_write_valid_i(aw), .sbreadonaddr_i(roa),
        .sbreadondata_i(rod), .sbautoincrement_i(ainc), .sbaccess_i(acc),
        .sbdata_i(sbdata), .sbdata_write_valid_i(dw),
        .sbdata_read_valid_i(dr), .sbaddress_o(sa64),
        .sbaddress_update_o(upd64), .sbdata_o(sd64), .sbdata_valid_o(dv64),
        .sbbusy_o(busy64), .sberror_valid_o(ev64), .sberror_o(err64)
    );

    dm_sba_bus #(.BusWidth(32)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive && use32),
        .master_req_o(req32), .master_add_o(add32), .master_we_o(we32),
        .master_wdata_o(wd32), .master_be_o(be32), .master_gnt_i(gnt),
        .master_r_valid_i(rvalid), .master_r_rdata_i(rdata[31:0]),
        .master_r_err_i(rerr), .sbaddress_i(sbaddress[31:0]),
        .sbaddress_write_valid_i(aw), .sbreadonaddr_i(roa),
        .sbreadondata_i(rod), .sbautoincrement_i(ainc), .sbaccess_i(acc),
        .sbdata_i(sbdata[31:0]), .sbdata_write_valid_i(dw),
        .sbdata_read_valid_i(dr), .sbaddress_o(sa32),
        .sbaddress_update_o(upd32), .sbdata_o(sd32), .sbdata_valid_o(dv32),
        .sbbusy_o(busy32), .sberror_valid_o(ev32), .sberror_o(err32)
    );

    logic        m_req, m_we, m_upd, m_dv, m_busy, m_ev;
    logic [63:0] m_add, m_wd, m_sa, m_sd;
    logic [7:0]  m_be;
    logic [2:0]  m_err;
    assign m_req  = use32 ? req32  : req64;
    assign m_we   = use32 ? we32   : we64;
    assign m_upd  = use32 ? upd32  : upd64;
    assign m_dv   = use32 ? dv32   : dv64;
    assign m_busy = use32 ? busy32 : busy64;
    assign m_ev   = use32 ? ev32   : ev64;
    assign m_err  = use32 ? err32  : err64;
    assign m_add  = use32 ? {32'h0, add32} : add64;
    assign m_wd   = use32 ? {32'h0, wd32}  : wd64;
    assign m_sa   = use32 ? {32'h0, sa32}  : sa64;
    assign m_sd   = use32 ? {32'h0, sd32}  : sd64;
    assign m_be   = use32 ? {4'h0, be32}   : be64;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // kind: 0 write, 1 read-on-address, 2 read-on-data
    typedef struct {
        bit          w32;
        int          kind;
        logic [2:0]  acc;
        logic [63:0] addr;
        logic [63:0] data;
        bit          ainc;
        logic [63:0] rdata;
        bit          rerr;
        logic [2:0]  perr;
        logic [63:0] e_add;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        logic [63:0] e_addr;
        bit          e_upd;
    } vec_t;

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        use32 = v.w32; acc = v.acc; sbaddress = v.addr; sbdata = v.data;
        ainc = v.ainc;
        roa = (v.kind == 1); rod = (v.kind == 2);
        aw = (v.kind == 1); dw = (v.kind == 0); dr = (v.kind == 2);
        #1;
        chk("pre_err_valid", m_ev, v.perr != 0);
        if (v.perr != 0) chk("pre_err_code", m_err, v.perr);
        @(negedge clk);
        aw = 0; dw = 0; dr = 0;
        sbaddress = ~v.addr; sbdata = ~v.data; acc = 3'd0; ainc = !v.ainc;
        #1;
        if (v.perr != 0) begin
            chk("pre_no_req", m_req, 0);
            chk("pre_no_busy", m_busy, 0);
            return;
        end
        chk("req", m_req, 1);
        chk("busy", m_busy, 1);
        chk("add", m_add, v.e_add);
        chk("be", m_be, v.e_be);
        chk("we", m_we, v.kind == 0);
        if (v.kind == 0) chk("wdata", m_wd, v.e_wdata);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        #1;
        chk("wait_req", m_req, 0);
        chk("wait_busy", m_busy, 1);
        @(negedge clk);
        rvalid = 1; rdata = v.rdata; rerr = v.rerr;
        #1;
        chk("dvalid", m_dv, (v.kind != 0) && !v.rerr);
        if (v.kind != 0 && !v.rerr) chk("sbdata", m_sd, v.e_rdata);
        chk("err_valid", m_ev, v.rerr);
        if (v.rerr) chk("err_code", m_err, 3'd2);
        chk("addr_upd", m_upd, v.e_upd);
        chk("sbaddress", m_sa, v.e_addr);
        @(negedge clk);
        rvalid = 0; rerr = 0;
        #1;
        chk("done_busy", m_busy, 0);
        chk("done_dvalid", m_dv, 0);
    endtask

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{0, 0, 3'd1, 64'h1006, 64'hBEEF, 0, 64'h0, 0, 3'd0,
                   64'h1000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 64'h1006, 0};
        vt[1]  = '{0, 1, 3'd2, 64'h2004, 64'h0, 1, 64'h1122_3344_5566_7788, 0, 3'd0,
                   64'h2000, 8'hF0, 64'h0, 64'h1122_3344, 64'h2008, 1};
        vt[2]  = '{1, 2, 3'd0, 64'h3003, 64'h0, 1, 64'hAABB_CCDD, 0, 3'd0,
                   64'h3000, 8'h08, 64'h0, 64'hAA, 64'h3004, 1};
        vt[3]  = '{1, 0, 3'd3, 64'h10, 64'h1, 0, 64'h0, 0, 3'd4,
                   64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0};
        vt[4]  = '{1, 1, 3'd2, 64'h3, 64'h0, 0, 64'h0, 0, 3'd3,
                   64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0};
        vt[5]  = '{0, 1, 3'd2, 64'h40, 64'h0, 1, 64'h5555, 1, 3'd0,
                   64'h40, 8'h0F, 64'h0, 64'h0, 64'h40, 0};
        vt[6]  = '{1, 0, 3'd2, 64'hFFFF_FFFC, 64'h1234_5678, 1, 64'h0, 0, 3'd0,
                   64'hFFFF_FFFC, 8'h0F, 64'h1234_5678, 64'h0, 64'h0, 1};
        vt[7]  = '{0, 0, 3'd3, 64'h8, 64'h0123_4567_89AB_CDEF, 1, 64'h0, 0, 3'd0,
                   64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h10, 1};
        vt[8]  = '{0, 1, 3'd4, 64'h0, 64'h0, 0, 64'h0, 0, 3'd4,
                   64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0};
        vt[9]  = '{0, 0, 3'd4, 64'h1, 64'h0, 0, 64'h0, 0, 3'd4,
                   64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0};
        vt[10] = '{0, 2, 3'd3, 64'h4, 64'h0, 0, 64'h0, 0, 3'd3,
                   64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0};
        vt[11] = '{0, 0, 3'd0, 64'h5, 64'hA5, 1, 64'h0, 1, 3'd0,
                   64'h0, 8'h20, 64'h0000_A500_0000_0000, 64'h0, 64'h5, 0};
        vt[12] = '{0, 2, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1,
                   64'hDEAD_BEEF_CAFE_BABE, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8,
                   8'hFF, 64'h0, 64'hDEAD_BEEF_CAFE_BABE, 64'h0, 1};
        vt[13] = '{0, 1, 3'd1, 64'h7A, 64'h0, 0, 64'h0000_0000_ABCD_1234, 0, 3'd0,
                   64'h78, 8'h0C, 64'h0, 64'hABCD, 64'h7A, 0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", req64, 0);
        chk("rst_add", add64, 0);
        chk("rst_we", we64, 0);
        chk("rst_wdata", wd64, 0);
        chk("rst_be", be64, 0);
        chk("rst_sbaddress", sa64, 0);
        chk("rst_upd", upd64, 0);
        chk("rst_sbdata", sd64, 0);
        chk("rst_dvalid", dv64, 0);
        chk("rst_busy", busy64, 0);
        chk("rst_errv", ev64, 0);
        chk("rst_err", err64, 0);
        chk("rst_req32", req32, 0);
        chk("rst_be32", be32, 0);
        rst_n = 1;

        foreach (vt[i]) run_vec(vt[i]);

        // 32-bit wrap read with a 5-cycle gnt stall and a trigger while busy
        @(negedge clk);
        use32 = 1; aw = 1; roa = 1; rod = 0; acc = 3'd2; ainc = 1;
        sbaddress = 64'hFFFF_FFFC;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            aw = 0; dw = (k == 2); sbaddress = 64'h100 + 64'(k);
            #1;
            chk("stall_req", m_req, 1);
            chk("stall_add", m_add, 64'hFFFF_FFFC);
            chk("stall_be", m_be, 8'h0F);
            chk("stall_we", m_we, 0);
            gnt = (k == 5);
        end
        @(negedge clk);
        gnt = 0; dw = 0;
        #1;
        chk("stall_wait_req", m_req, 0);
        @(negedge clk);
        rvalid = 1; rdata = 64'hCAFE_F00D;
        #1;
        chk("stall_dvalid", m_dv, 1);
        chk("stall_sbdata", m_sd, 64'hCAFE_F00D);
        chk("stall_upd", m_upd, 1);
        chk("stall_wrap", m_sa, 0);
        @(negedge clk);
        rvalid = 0;
        #1;
        chk("stall_idle_busy", m_busy, 0);
        chk("stall_idle_req", m_req, 0);

        // dmactive dropped in WAIT_READ
        @(negedge clk);
        use32 = 0; aw = 1; roa = 1; acc = 3'd3; ainc = 1; sbaddress = 64'h100;
        @(negedge clk);
        aw = 0;
        #1;
        chk("drop_req", m_req, 1);
        gnt = 1;
        @(negedge clk);
        gnt = 0; dmactive = 0;
        #1;
        chk("drop_busy", m_busy, 1);
        @(negedge clk);
        rvalid = 1; rdata = 64'h1234;
        #1;
        chk("drop_dvalid", m_dv, 0);
        chk("drop_errv", m_ev, 0);
        chk("drop_upd", m_upd, 0);
        @(negedge clk);
        rvalid = 0; dmactive = 1;
        #1;
        chk("drop_idle", m_busy, 0);

        // Inactive module ignores triggers
        @(negedge clk);
        dmactive = 0; dw = 1; acc = 3'd0; sbaddress = 64'h0;
        #1;
        chk("inact_errv", m_ev, 0);
        @(negedge clk);
        dw = 0; dmactive = 1;
        #1;
        chk("inact_busy", m_busy, 0);
        chk("inact_req", m_req, 0);

        // Read-on-address beats a simultaneous sbdata write
        @(negedge clk);
        aw = 1; roa = 1; dw = 1; acc = 3'd2; ainc = 0; sbaddress = 64'h20;
        @(negedge clk);
        aw = 0; dw = 0;
        #1;
        chk("prio_req", m_req, 1);
        chk("prio_we", m_we, 0);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        @(negedge clk);
        rvalid = 1; rdata = 64'h77;
        #1;
        chk("prio_dvalid", m_dv, 1);
        chk("prio_sbdata", m_sd, 64'h77);
        @(negedge clk);
        rvalid = 0;

        // Stray response while idle
        @(negedge clk);
        rvalid = 1; rerr = 1;
        #1;
        chk("stray_dvalid", m_dv, 0);
        chk("stray_errv", m_ev, 0);
        chk("stray_busy", m_busy, 0);
        @(negedge clk);
        rvalid = 0; rerr = 0;

        // Asynchronous reset during READ
        @(negedge clk);
        aw = 1; roa = 1; acc = 3'd2; ainc = 1; sbaddress = 64'h40;
        @(negedge clk);
        aw = 0;
        #1;
        chk("rstmid_req_before", m_req, 1);
        #1;
        rst_n = 0;
        #1;
        chk("rstmid_req", m_req, 0);
        chk("rstmid_busy", m_busy, 0);
        chk("rstmid_sbaddress", m_sa, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("rstmid_after_busy", m_busy, 0);
        chk("rstmid_after_req", m_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
